uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 104, giving the number of clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame (legal values 1 or 2).
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port tx_data  input  8  byte to transmit, sampled only on acceptance.
REQ-006 The block SHALL have port tx_valid  input  1  producer offers tx_data.
REQ-007 The block SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have port tx  output  1  serial line; idle level 1.
REQ-009 The block SHALL have port busy  output  1  a frame is in progress.

Function
REQ-010 The block SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-011 A byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1, and only then.
REQ-012 tx_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be its complement.
REQ-013 On acceptance the block SHALL latch tx_data, enter START, and drive tx=0 from that same edge (one-cycle latency, valid-to-tx-low).
REQ-014 Every bit (start, data, parity, stop) SHALL last exactly CLK_DIV clk cycles, timed by a baud counter reloaded at each bit boundary.
REQ-015 DATA SHALL send the latched byte LSB first, bit 0 through bit 7, then go to PARITY (if compiled in) or STOP.
REQ-016 STOP SHALL drive tx=1 for STOP_BITS*CLK_DIV cycles, then return to IDLE.
REQ-017 Transitions: IDLE->START on acceptance; START->DATA after one bit; DATA->PARITY/STOP after 8 bits; PARITY->STOP after one bit; STOP->IDLE after the stop time.
REQ-018 Changes to tx_data or tx_valid while busy=1 SHALL have no effect on the frame in progress.
REQ-019 With tx_valid held at 1 continuously, consecutive frames SHALL be separated by exactly one IDLE cycle with tx=1 (frame period = (10+STOP_BITS-1)*CLK_DIV+1 cycles without parity).
REQ-020 tx SHALL be driven from a register, glitch-free, and SHALL be 1 in IDLE.
REQ-021 The baud counter SHALL be wide enough for CLK_DIV-1 with no wrap-around inside a bit.

Reset
REQ-022 Asserting rst SHALL immediately, without a clock edge, force state IDLE, tx=1, tx_ready=1, busy=0, and clear the baud counter, bit index and latched byte.
REQ-023 Asserting rst mid-frame SHALL abort the frame; no partial bits SHALL resume after release.
REQ-024 The first acceptance after rst deasserts SHALL be possible on the first rising edge where tx_valid=1.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the block SHALL insert one PARITY bit after bit 7, equal to the XOR of the 8 latched data bits (even parity), lasting CLK_DIV cycles.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state SHALL be unreachable and the frame SHALL be start + 8 data + STOP_BITS stop bits.

Verification
REQ-027 CLK_DIV=4, STOP_BITS=1, no parity; send 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; tx_ready=0 for 40 cycles.
REQ-028 CLK_DIV=4, tx_valid held, bytes 0xA5 then 0x3C -> two back-to-back frames with exactly one idle-high cycle between them; bits LSB first.
REQ-029 CLK_DIV=4, change tx_data 0x0F->0xFF during DATA of a 0x0F frame -> serial data stays 1,1,1,1,0,0,0,0.
REQ-030 CLK_DIV=4, assert rst during data bit 3 of 0x00 -> tx=1, tx_ready=1 before the next clock edge; no further low bits after release.
REQ-031 UART_TX_PARITY_EN defined, CLK_DIV=4, send 0x07 -> parity bit 1 after bit 7; send 0x03 -> parity bit 0; frame length 44 cycles.
REQ-032 CLK_DIV=4, STOP_BITS=2, send 0xFF -> stop high 8 cycles, tx_ready rises after 44 cycles.

Source files
------------

// File: rtl/uart_tx_core.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after data bit 7.
module uart_tx_core #(
  parameter int CLK_DIV   = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and does not depend on tx_valid.

  localparam int                CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic             stop_idx, stop_idx_n;
  logic [7:0]       data_q, data_n;
  logic             tx_q, tx_n;
  logic             baud_done;

  assign baud_done = (baud_cnt == '0);
  assign tx_ready  = (state == IDLE);
  assign busy      = ~tx_ready;
  assign tx        = tx_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      data_q   <= data_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    data_n     = data_q;
    tx_n       = tx_q;

    if (state == IDLE) begin
      tx_n = 1'b1;
      if (tx_valid) begin
        state_n    = START;
        data_n     = tx_data;
        baud_cnt_n = BAUD_LAST;
        bit_idx_n  = '0;
        stop_idx_n = 1'b0;
        tx_n       = 1'b0;
      end
    end else if (!baud_done) begin
      baud_cnt_n = baud_cnt - CNT_W'(1);
    end else begin
      // Bit boundary: reload the counter and present the next bit on tx.
      baud_cnt_n = BAUD_LAST;
      case (state)
        START: begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = data_q[0];
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^data_q;
`else
            state_n    = STOP;
            stop_idx_n = 1'b0;
            tx_n       = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = data_q[bit_idx + 3'd1];
          end
        end
        PARITY: begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
          tx_n       = 1'b1;
        end
        STOP: begin
          tx_n = 1'b1;
          if (stop_idx == STOP_LAST) begin
            state_n    = IDLE;
            baud_cnt_n = '0;
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end
        default: begin
          state_n    = IDLE;
          baud_cnt_n = '0;
          tx_n       = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with CLK_DIV=4: one-stop and two-stop instances,
// expectations adapt when UART_TX_PARITY_EN is defined.
module tb_uart_tx_core;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] state_dbg;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;
  logic [2:0] state_dbg2;

  int         checks = 0;
  int         failures = 0;
  int         change_at = -1;
  logic [7:0] change_val = 8'h00;

  always #5 clk = ~clk;

  uart_tx_core #(.CLK_DIV(CLK_DIV), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .state_dbg(state_dbg)
  );

  uart_tx_core #(.CLK_DIV(CLK_DIV), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .state_dbg(state_dbg2)
  );

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / CLK_DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int frame_len(input int stops);
    return (9 + PAR + stops) * CLK_DIV;
  endfunction

  // Entered at the negedge right after the acceptance edge (k=0); leaves at k=n-1.
  task automatic check_frame(input logic [7:0] b, input bit use2, input string name);
    int   n;
    logic o_tx, o_rdy, o_busy, e_tx;
    n = frame_len(use2 ? 2 : 1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      o_tx   = use2 ? tx2 : tx;
      o_rdy  = use2 ? tx_ready2 : tx_ready;
      o_busy = use2 ? busy2 : busy;
      e_tx   = exp_bit(b, k);
      checks++;
      if (o_tx !== e_tx) begin
        failures++;
        $display("FAIL %s_tx byte=%h cycle=%0d got=%b exp=%b", name, b, k, o_tx, e_tx);
      end
      checks++;
      if (o_rdy !== 1'b0 || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy byte=%h cycle=%0d got ready=%b busy=%b exp ready=0 busy=1",
                 name, b, k, o_rdy, o_busy);
      end
      if (k == change_at) tx_data = change_val;
    end
  endtask

  task automatic check_idle(input bit use2, input string name);
    logic o_tx, o_rdy, o_busy;
    o_tx   = use2 ? tx2 : tx;
    o_rdy  = use2 ? tx_ready2 : tx_ready;
    o_busy = use2 ? busy2 : busy;
    checks++;
    if (o_tx !== 1'b1 || o_rdy !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s got tx=%b ready=%b busy=%b exp tx=1 ready=1 busy=0",
               name, o_tx, o_rdy, o_busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_idle(1'b0, "reset_state");
    check_idle(1'b1, "reset_state2");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle(1'b0, "reset_release");
  endtask

  task automatic test_single_frames();
    logic [7:0] pats [4];
    pats[0] = 8'h55; pats[1] = 8'h00; pats[2] = 8'hFF; pats[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle(1'b0, "single_pre");
      tx_data  = pats[i];
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_frame(pats[i], 1'b0, "single");
      @(negedge clk);
      check_idle(1'b0, "single_end");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    check_frame(8'hA5, 1'b0, "b2b_first");
    @(negedge clk);
    check_idle(1'b0, "b2b_gap");
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(8'h3C, 1'b0, "b2b_second");
    @(negedge clk);
    check_idle(1'b0, "b2b_end");
  endtask

  task automatic test_data_change();
    @(negedge clk);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid   = 1'b0;
    change_at  = 6;
    change_val = 8'hFF;
    check_frame(8'h0F, 1'b0, "data_change");
    change_at = -1;
    @(negedge clk);
    check_idle(1'b0, "data_change_end");
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL midframe_bit3 got=%b exp=0", tx);
    end
    #1 rst = 1'b1;
    #1 check_idle(1'b0, "rst_async");
    #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check_idle(1'b0, "rst_no_resume");
    end
  endtask

  task automatic test_accept_after_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(8'h96, 1'b0, "post_reset");
    @(negedge clk);
    check_idle(1'b0, "post_reset_end");
  endtask

  task automatic test_parity();
    logic [7:0] pats [2];
    pats[0] = 8'h07; pats[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tx_data  = pats[i];
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_frame(pats[i], 1'b0, "parity");
      @(negedge clk);
      check_idle(1'b0, "parity_end");
    end
  endtask

  task automatic test_two_stop();
    @(negedge clk);
    check_idle(1'b1, "two_stop_pre");
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    check_frame(8'hFF, 1'b1, "two_stop");
    @(negedge clk);
    check_idle(1'b1, "two_stop_end");
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_data_change();
    test_reset_midframe();
    test_accept_after_reset();
    test_parity();
    test_two_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
